send_cmd_dispatcher: RTL and testbench
======================================

Name: send_cmd_dispatcher

Overview:
- Converts PCIe-side send requests (6-bit slot index plus strobe) into DDR start addresses.
- Queues them and issues one-cycle cmd_send pulses to the two send_packet channels in round-robin order.
- Sits directly upstream of send_packet_1_control and send_packet_2_control. Consumes pcie_send_control, ddr_ready and mac_inited.
- Enforces a minimum per-channel spacing so a channel is not re-commanded while it may still be transmitting.

Parameters:
- ADDR_BASE, 25'h0000000: DDR base address of the slot area.
- SLOT_SHIFT, 10: log2 of slot stride in DDR words.
- FIFO_DEPTH, 8: command queue depth; power of 2, minimum 2.
- GAP_CYCLES, 1500: minimum clock cycles between successive cmd_send pulses on the same channel.
- GAP_W, 16: gap counter width; must satisfy GAP_CYCLES < 2^GAP_W.

Ports:
- clk_clk  in  1  single clock; all logic is on its rising edge.
- reset_reset_n  in  1  asynchronous assert, active-low reset.
- pcie_send_control_signal  in  1  request strobe, level; its rising edge is the request.
- pcie_send_control_start_ram_addr  in  6  slot index; valid in the cycle the strobe rises.
- ddr_ready_ram_ready  in  1  DDR is usable.
- mac_inited_mac_inited  in  1  MACs are configured.
- send_packet_1_control_start_ram_addr  out  25  channel 1 start address.
- send_packet_1_control_cmd_send  out  1  channel 1 start pulse.
- send_packet_2_control_start_ram_addr  out  25  channel 2 start address.
- send_packet_2_control_cmd_send  out  1  channel 2 start pulse.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued commands.
- overflow  out  1  sticky flag: a request was dropped because the queue was full.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0.
  - FIFO is emptied, the FSM goes to IDLE, the round-robin pointer goes to channel 1, and both gap counters go to 0.
  - Assertion mid-operation aborts any pending pulse immediately; nothing is replayed after reset.
- Edge detect:
  - sig_q is the registered strobe.
  - A request is counted at edge N when the strobe is 1 and sig_q is 0.
  - The slot index is captured at that same edge.
- Push:
  - If the FIFO is not full, the slot is written at edge N.
  - If the FIFO is full, the request is dropped and overflow is set to 1. overflow clears only on reset.
- Address computation: ADDR_BASE + (slot << SLOT_SHIFT), truncated to 25 bits. Wrap-around past 2^25 is silent.
- Enable: en = ddr_ready_ram_ready & mac_inited_mac_inited. en is sampled only in IDLE.
- Channel readiness: a channel is ready when its gap counter is 0.
- FSM states: IDLE, SELECT, PULSE.
  - IDLE -> SELECT when the FIFO is not empty, en = 1 and at least one channel is ready.
  - Channel choice: the round-robin pointer's channel if it is ready, otherwise the other channel.
  - SELECT: pop the FIFO and register the computed address into the chosen channel's start_ram_addr. The other channel's address is unchanged. -> PULSE.
  - PULSE: the chosen channel's cmd_send is 1 for exactly this cycle. Load that channel's gap counter with GAP_CYCLES. Set the round-robin pointer to the other channel. -> IDLE.
  - Once SELECT is entered, the dispatch completes even if en drops.
- Latency, request at edge N with an empty queue and an idle channel:
  - Address output is valid after edge N+2.
  - cmd_send is high from edge N+3 to edge N+4.
  - The address is held stable until the next dispatch to the same channel.
- Throughput: at most one dispatch per 3 cycles.
- Gap counters: decrement by 1 per cycle while nonzero and saturate at 0. Loading in PULSE overrides the decrement.
- FIFO accounting:
  - A simultaneous push and pop in the SELECT cycle is legal; fifo_level is unchanged.
  - A push to a full FIFO in the same cycle as a pop is still dropped: fullness is judged before the pop.
- Both cmd_send outputs are never high in the same cycle.

Decomposition:
- Package send_ctrl_pkg holds:
  - ADDR_W=25 and SLOT_W=6.
  - typedef chan_t as the 1-bit channel id {CH1, CH2}.
  - typedef disp_state_t {IDLE, SELECT, PULSE}.
- One sub-module, cmd_slot_fifo: a synchronous FIFO of SLOT_W-bit entries with push, pop, full, empty and level. It uses the same clock and asynchronous active-low reset.

Test Plan (GAP_CYCLES=100, ADDR_BASE=0, SLOT_SHIFT=10):
- Single request, slot 5, en=1 -> send_packet_1 address 25'h0001400; ch1 cmd_send high 1 cycle, 3 edges after the strobe edge; ch2 stays 0.
- Two requests, slots 1 and 2, 4 cycles apart -> ch1 receives 25'h400 and ch2 receives 25'h800; the two pulses are at least 3 cycles apart and alternate.
- Three requests within 12 cycles -> the third goes to ch1 no sooner than 100 cycles after ch1's first pulse; fifo_level reads 1 while it waits.
- Hold ddr_ready=0 and issue 9 requests (depth 8) -> fifo_level=8, overflow=1, no pulses. Raise ddr_ready -> exactly 8 pulses in order, alternating channels, spaced by the gap.
- Strobe held high for 20 cycles -> exactly one request is queued.
- Assert reset during PULSE -> cmd_send drops to 0 asynchronously; after release, level=0, overflow=0, addresses=0, and the next request goes to ch1.

Source files
------------

// File: rtl/send_ctrl_pkg.sv
// Shared types and the slot-to-DDR address helper for the send command dispatcher.
package send_ctrl_pkg;

    localparam int ADDR_W = 25;
    localparam int SLOT_W = 6;

    typedef enum logic {
        CH1 = 1'b0,
        CH2 = 1'b1
    } chan_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        PULSE  = 2'd2
    } disp_state_t;

    // Slot start address; anything past 2^ADDR_W wraps silently.
    function automatic logic [ADDR_W-1:0] slot_to_addr(
        input logic [ADDR_W-1:0] base,
        input logic [SLOT_W-1:0] slot,
        input int unsigned       shift
    );
        logic [ADDR_W-1:0] offset;
        offset = ADDR_W'(slot) << shift;
        return base + offset;
    endfunction

endpackage

// File: rtl/cmd_slot_fifo.sv
// Synchronous FIFO of slot indices; push is ignored when full, pop when empty.
module cmd_slot_fifo
    import send_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [SLOT_W-1:0]      push_data,
    input  logic                   pop,
    output logic [SLOT_W-1:0]      pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [SLOT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic              do_push_s;
    logic              do_pop_s;

    // Qualify requests against the occupancy seen before this edge.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (push && (count_r != FULL_CNT)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
        if (pop && (count_r != {(PTR_W+1){1'b0}})) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {SLOT_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = (count_r == FULL_CNT);
    assign empty    = (count_r == {(PTR_W+1){1'b0}});
    assign level    = count_r;

endmodule

// File: rtl/send_cmd_dispatcher.sv
// Queues PCIe send requests and dispatches them round-robin to two send_packet
// channels, keeping a minimum spacing between pulses on the same channel.
module send_cmd_dispatcher
    import send_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_BASE  = 25'h0000000,
    parameter int unsigned       SLOT_SHIFT = 10,
    parameter int                FIFO_DEPTH = 8,
    parameter int unsigned       GAP_CYCLES = 1500,
    parameter int                GAP_W      = 16
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic                        pcie_send_control_signal,
    input  logic [SLOT_W-1:0]           pcie_send_control_start_ram_addr,
    input  logic                        ddr_ready_ram_ready,
    input  logic                        mac_inited_mac_inited,
    output logic [ADDR_W-1:0]           send_packet_1_control_start_ram_addr,
    output logic                        send_packet_1_control_cmd_send,
    output logic [ADDR_W-1:0]           send_packet_2_control_start_ram_addr,
    output logic                        send_packet_2_control_cmd_send,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};

    disp_state_t       state_r;
    chan_t             rr_r;
    chan_t             chan_r;
    chan_t             pick_s;
    logic [GAP_W-1:0]  gap1_r;
    logic [GAP_W-1:0]  gap2_r;
    logic              rdy1_s;
    logic              rdy2_s;
    logic              en_s;
    logic              sig_q_r;
    logic              req_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;
    logic [SLOT_W-1:0] head_s;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] addr1_r;
    logic [ADDR_W-1:0] addr2_r;
    logic              cmd1_r;
    logic              cmd2_r;
    logic              overflow_r;

    cmd_slot_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .push      (req_s),
        .push_data (pcie_send_control_start_ram_addr),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .level     (fifo_level)
    );

    // Request detection, readiness and channel choice.
    always_comb begin
        req_s  = pcie_send_control_signal & ~sig_q_r;
        en_s   = ddr_ready_ram_ready & mac_inited_mac_inited;
        rdy1_s = (gap1_r == GAP_ZERO);
        rdy2_s = (gap2_r == GAP_ZERO);
        pop_s  = (state_r == SELECT);
        addr_s = slot_to_addr(ADDR_BASE, head_s, SLOT_SHIFT);
        pick_s = CH1;
        if (rr_r == CH1) begin
            if (rdy1_s) begin
                pick_s = CH1;
            end else begin
                pick_s = CH2;
            end
        end else begin
            if (rdy2_s) begin
                pick_s = CH2;
            end else begin
                pick_s = CH1;
            end
        end
    end

    // Registered strobe for edge detect and sticky drop flag.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sig_q_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            sig_q_r <= pcie_send_control_signal;
            if (req_s && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Dispatch FSM with its address, pulse and gap-counter registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r <= IDLE;
            rr_r    <= CH1;
            chan_r  <= CH1;
            gap1_r  <= GAP_ZERO;
            gap2_r  <= GAP_ZERO;
            addr1_r <= {ADDR_W{1'b0}};
            addr2_r <= {ADDR_W{1'b0}};
            cmd1_r  <= 1'b0;
            cmd2_r  <= 1'b0;
        end else begin
            cmd1_r <= 1'b0;
            cmd2_r <= 1'b0;
            if (!rdy1_s) begin
                gap1_r <= gap1_r - GAP_ONE;
            end
            if (!rdy2_s) begin
                gap2_r <= gap2_r - GAP_ONE;
            end
            case (state_r)
                IDLE: begin
                    if (!empty_s && en_s && (rdy1_s || rdy2_s)) begin
                        chan_r  <= pick_s;
                        state_r <= SELECT;
                    end
                end
                SELECT: begin
                    if (chan_r == CH1) begin
                        addr1_r <= addr_s;
                    end else begin
                        addr2_r <= addr_s;
                    end
                    state_r <= PULSE;
                end
                PULSE: begin
                    // The gap load deliberately overrides the decrement above.
                    if (chan_r == CH1) begin
                        cmd1_r <= 1'b1;
                        gap1_r <= GAP_LOAD;
                        rr_r   <= CH2;
                    end else begin
                        cmd2_r <= 1'b1;
                        gap2_r <= GAP_LOAD;
                        rr_r   <= CH1;
                    end
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign send_packet_1_control_start_ram_addr = addr1_r;
    assign send_packet_2_control_start_ram_addr = addr2_r;
    assign send_packet_1_control_cmd_send       = cmd1_r;
    assign send_packet_2_control_cmd_send       = cmd2_r;
    assign overflow                             = overflow_r;

endmodule

// File: tb/tb_send_cmd_dispatcher.sv
// Directed bench for send_cmd_dispatcher: table of single dispatches plus
// hand-written multi-cycle sequences (gap wait, overflow, held strobe, reset).
module tb_send_cmd_dispatcher;

    logic        clk;
    logic        rst_n;
    logic        sig;
    logic [5:0]  slot;
    logic        ddr_rdy;
    logic        mac_ok;
    logic [24:0] addr1;
    logic        cmd1;
    logic [24:0] addr2;
    logic        cmd2;
    logic [3:0]  level;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic        ch;
        int unsigned t;
        logic [24:0] addr;
    } pulse_t;
    pulse_t log_q[$];

    typedef struct {
        logic [5:0]  slot;
        logic        ch;
        logic [24:0] addr;
    } vec_t;
    vec_t vecs[5];

    send_cmd_dispatcher #(
        .ADDR_BASE  (25'h0000000),
        .SLOT_SHIFT (10),
        .FIFO_DEPTH (8),
        .GAP_CYCLES (100),
        .GAP_W      (16)
    ) dut (
        .clk_clk                              (clk),
        .reset_reset_n                        (rst_n),
        .pcie_send_control_signal             (sig),
        .pcie_send_control_start_ram_addr     (slot),
        .ddr_ready_ram_ready                  (ddr_rdy),
        .mac_inited_mac_inited                (mac_ok),
        .send_packet_1_control_start_ram_addr (addr1),
        .send_packet_1_control_cmd_send       (cmd1),
        .send_packet_2_control_start_ram_addr (addr2),
        .send_packet_2_control_cmd_send       (cmd2),
        .fifo_level                           (level),
        .overflow                             (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse logger and channel mutual-exclusion check.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (cmd1 && cmd2) begin
                n_fail++;
                $display("FAIL cmd_exclusive: both cmd_send high at cycle %0d, required at most one", cyc);
            end
            if (cmd1) log_q.push_back('{1'b0, cyc, addr1});
            if (cmd2) log_q.push_back('{1'b1, cyc, addr2});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe rises before edge N, falls after it; returns just after edge N+1.
    task automatic req(input logic [5:0] s);
        sig  = 1'b1;
        slot = s;
        tick();
        sig = 1'b0;
        tick();
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        sig     = 1'b0;
        slot    = 6'd0;
        ddr_rdy = 1'b1;
        mac_ok  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        log_q.delete();
    endtask

    task automatic wait_pulses(input int n, input int budget, input string name);
        int k;
        k = 0;
        while ((log_q.size() < n) && (k < budget)) begin
            tick();
            k++;
        end
        chk(name, 32'(log_q.size()), 32'(n));
    endtask

    task automatic do_single(input int idx, input logic [5:0] s, input logic ch, input logic [24:0] exp_addr);
        string tag;
        tag = $sformatf("vec%0d", idx);
        req(s);
        tick();
        chk({tag, "_addr_n2"}, 32'(ch ? addr2 : addr1), 32'(exp_addr));
        chk({tag, "_no_cmd_n2"}, 32'({cmd1, cmd2}), 32'd0);
        tick();
        chk({tag, "_cmd_n3"}, 32'({cmd2, cmd1}), ch ? 32'd2 : 32'd1);
        tick();
        chk({tag, "_cmd_n4"}, 32'({cmd1, cmd2}), 32'd0);
        chk({tag, "_addr_held"}, 32'(ch ? addr2 : addr1), 32'(exp_addr));
    endtask

    initial begin
        vecs[0] = '{6'd5,  1'b0, 25'h0001400};
        vecs[1] = '{6'd1,  1'b1, 25'h0000400};
        vecs[2] = '{6'd2,  1'b0, 25'h0000800};
        vecs[3] = '{6'd63, 1'b1, 25'h000FC00};
        vecs[4] = '{6'd0,  1'b0, 25'h0000000};

        apply_reset();
        chk("rst_cmd1", 32'(cmd1), 32'd0);
        chk("rst_cmd2", 32'(cmd2), 32'd0);
        chk("rst_addr1", 32'(addr1), 32'd0);
        chk("rst_addr2", 32'(addr2), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(ovf), 32'd0);

        // Single dispatches, spaced beyond the gap so they alternate channels.
        for (int i = 0; i < 5; i++) begin
            do_single(i, vecs[i].slot, vecs[i].ch, vecs[i].addr);
            repeat (110) tick();
        end

        // Slots 1,2,3 pushed 4 cycles apart: third waits for channel 1's gap.
        apply_reset();
        req(6'd1);
        tick(); tick();
        req(6'd2);
        tick(); tick();
        req(6'd3);
        repeat (8) tick();
        chk("two_req_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() >= 2) begin
            chk("two_req_ch1", 32'({log_q[0].ch, log_q[0].addr}), 32'({1'b0, 25'h0000400}));
            chk("two_req_ch2", 32'({log_q[1].ch, log_q[1].addr}), 32'({1'b1, 25'h0000800}));
            chk("two_req_spacing", 32'((log_q[1].t - log_q[0].t) >= 3), 32'd1);
        end
        repeat (30) tick();
        chk("third_waiting_level", 32'(level), 32'd1);
        wait_pulses(3, 200, "third_dispatched");
        if (log_q.size() >= 3) begin
            chk("third_to_ch1", 32'({log_q[2].ch, log_q[2].addr}), 32'({1'b0, 25'h0000C00}));
            chk("third_gap", 32'((log_q[2].t - log_q[0].t) >= 100), 32'd1);
        end

        // Strobe held high for 20 cycles queues exactly one request.
        apply_reset();
        ddr_rdy = 1'b0;
        sig     = 1'b1;
        slot    = 6'd20;
        repeat (20) tick();
        sig = 1'b0;
        tick();
        chk("held_level", 32'(level), 32'd1);
        ddr_rdy = 1'b1;
        repeat (20) tick();
        chk("held_pulses", 32'(log_q.size()), 32'd1);
        if (log_q.size() >= 1) begin
            chk("held_addr", 32'(log_q[0].addr), 32'(25'h0005000));
        end

        // Nine requests into a disabled queue of eight, then drain.
        apply_reset();
        ddr_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            req(6'(10 + i));
        end
        chk("ovf_level", 32'(level), 32'd8);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_no_pulse", 32'(log_q.size()), 32'd0);
        ddr_rdy = 1'b1;
        wait_pulses(8, 1000, "drain_count");
        repeat (200) tick();
        chk("drain_no_extra", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < log_q.size()) begin
                chk($sformatf("drain%0d_addr", i), 32'(log_q[i].addr), 32'((10 + i) << 10));
                chk($sformatf("drain%0d_ch", i), 32'(log_q[i].ch), 32'(i % 2));
                if (i >= 1) chk($sformatf("drain%0d_space", i), 32'((log_q[i].t - log_q[i-1].t) >= 3), 32'd1);
                if (i >= 2) chk($sformatf("drain%0d_gap", i), 32'((log_q[i].t - log_q[i-2].t) >= 100), 32'd1);
            end
        end
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_ovf_sticky", 32'(ovf), 32'd1);

        // Reset asserted while a pulse is high aborts it at once.
        repeat (120) tick();
        log_q.delete();
        req(6'd7);
        tick();
        tick();
        chk("pre_rst_cmd1", 32'(cmd1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cmds", 32'({cmd1, cmd2}), 32'd0);
        chk("async_rst_addr1", 32'(addr1), 32'd0);
        chk("async_rst_addr2", 32'(addr2), 32'd0);
        chk("async_rst_level", 32'(level), 32'd0);
        chk("async_rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick();
        chk("no_replay", 32'(log_q.size()), 32'd0);
        req(6'd9);
        wait_pulses(1, 20, "post_rst_pulse");
        if (log_q.size() >= 1) begin
            chk("post_rst_ch1", 32'({log_q[0].ch, log_q[0].addr}), 32'({1'b0, 25'h0002400}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
